// File: rtl/iodelay_sequencer.sv
// iodelay_sequencer: shadow tap table applied channel by channel to an IODELAY bank
module iodelay_sequencer #(
  parameter int NCHAN    = 21,
  parameter int UPD_HIGH = 2,
  parameter int UPD_GAP  = 4
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       IDELAYCTRL_RDY,
  input  logic       CFG_WE,
  input  logic [7:0] CFG_ADDR,
  input  logic [4:0] CFG_WDATA,
  output logic [4:0] CFG_RDATA,
  input  logic       START,
  output logic       BUSY,
  output logic       DONE,
  output logic [7:0] DELAY_CHANNEL,
  output logic [4:0] DELAY_VALUE,
  output logic       DELAY_UPDATE
);
  localparam int AW = NCHAN > 1 ? $clog2(NCHAN) : 1;
  localparam logic [8:0] NCH = 9'(NCHAN);
  localparam logic [7:0] LAST = 8'(NCHAN - 1);
  typedef enum logic [2:0] {IDLE, WAIT_RDY, SETUP, PULSE, HOLD, FIN} state_t;
  state_t state;
  logic [4:0] tbl [NCHAN];
  logic [7:0] ch, cnt;
  logic [1:0] rdy_s;
  logic start_q, pending;
  logic start_edge, addr_ok;
  assign start_edge = START & ~start_q;
  assign addr_ok = {1'b0, CFG_ADDR} < NCH;
  // RDY double-flop synchroniser and START edge register
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      rdy_s <= '0;
      start_q <= 1'b0;
    end else begin
      rdy_s <= {rdy_s[0], IDELAYCTRL_RDY};
      start_q <= START;
    end
  // Shadow table: writes outside the channel range are dropped, reads there return 0
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      for (int i = 0; i < NCHAN; i++) tbl[i] <= '0;
      CFG_RDATA <= '0;
    end else begin
      if (CFG_WE && addr_ok) tbl[CFG_ADDR[AW-1:0]] <= CFG_WDATA;
      CFG_RDATA <= addr_ok ? tbl[CFG_ADDR[AW-1:0]] : '0;
    end
  // Sequencer: channel/value latched only on entry to SETUP so they are stable around every pulse
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      state <= IDLE;
      ch <= '0;
      cnt <= '0;
      pending <= 1'b0;
      BUSY <= 1'b0;
      DONE <= 1'b0;
      DELAY_CHANNEL <= '0;
      DELAY_VALUE <= '0;
      DELAY_UPDATE <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (start_edge && state != IDLE && state != FIN) pending <= 1'b1;
      case (state)
        IDLE: if (start_edge) begin
          ch <= '0;
          BUSY <= 1'b1;
          state <= WAIT_RDY;
        end
        WAIT_RDY: if (rdy_s[1]) begin
          DELAY_CHANNEL <= ch;
          DELAY_VALUE <= tbl[ch[AW-1:0]];
          state <= SETUP;
        end
        SETUP: begin
          DELAY_UPDATE <= 1'b1;
          cnt <= 8'(UPD_HIGH - 1);
          state <= PULSE;
        end
        PULSE: if (cnt == '0) begin
          DELAY_UPDATE <= 1'b0;
          cnt <= 8'(UPD_GAP - 1);
          state <= HOLD;
        end else cnt <= cnt - 1'b1;
        HOLD: if (cnt == '0) begin
          if (ch < LAST) begin
            ch <= ch + 1'b1;
            state <= WAIT_RDY;
          end else begin
            DONE <= 1'b1;
            BUSY <= 1'b0;
            state <= FIN;
          end
        end else cnt <= cnt - 1'b1;
        FIN: if (pending || start_edge) begin
          pending <= 1'b0;
          ch <= '0;
          BUSY <= 1'b1;
          state <= WAIT_RDY;
        end else state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_iodelay_sequencer.sv
// tb_iodelay_sequencer: scoreboard bench for iodelay_sequencer
module tb_iodelay_sequencer;
  localparam int N = 21;
  logic CLK = 1'b0, RESET_N = 1'b0, RDY = 1'b1, CFG_WE = 1'b0, START = 1'b0;
  logic [7:0] CFG_ADDR = '0;
  logic [4:0] CFG_WDATA = '0;
  logic [4:0] CFG_RDATA, DELAY_VALUE;
  logic [7:0] DELAY_CHANNEL;
  logic BUSY, DONE, DELAY_UPDATE;
  typedef struct {int ch; int val; int t;} pulse_t;
  pulse_t pq[$];
  int dq[$];
  int mdl [N];
  int cyc = 0, vectors = 0, miscompares = 0;
  iodelay_sequencer #(.NCHAN(N), .UPD_HIGH(2), .UPD_GAP(4)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .IDELAYCTRL_RDY(RDY), .CFG_WE(CFG_WE),
    .CFG_ADDR(CFG_ADDR), .CFG_WDATA(CFG_WDATA), .CFG_RDATA(CFG_RDATA),
    .START(START), .BUSY(BUSY), .DONE(DONE), .DELAY_CHANNEL(DELAY_CHANNEL),
    .DELAY_VALUE(DELAY_VALUE), .DELAY_UPDATE(DELAY_UPDATE)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic go_to(input int c);
    while (cyc < c) tick();
  endtask
  task automatic wr(input int a, input int d);
    CFG_WE = 1'b1;
    CFG_ADDR = 8'(a);
    CFG_WDATA = 5'(d);
    tick();
    CFG_WE = 1'b0;
    if (a < N) mdl[a] = d;
  endtask
  task automatic rd(input int a, input int e, input string nm);
    CFG_ADDR = 8'(a);
    tick();
    chk(nm, int'(CFG_RDATA), e);
  endtask
  task automatic start_seq(output int k);
    START = 1'b1;
    k = cyc;
    tick();
    tick();
    START = 1'b0;
  endtask
  task automatic pulse_start();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask
  // expected pulses of one sequence whose START rose in cycle k; channels >= sc are delayed by st
  task automatic push_seq(input int k, input int n, input int sc, input int st);
    for (int i = 0; i < n; i++) pq.push_back('{i, mdl[i], k + 3 + 8 * i + (i >= sc ? st : 0)});
    if (n == N) dq.push_back(k + 169 + st);
  endtask
  task automatic drain(input int budget);
    int w = 0;
    while ((pq.size() != 0 || dq.size() != 0) && w < budget) begin
      tick();
      w++;
    end
    chk("drain_timeout_left", pq.size() + dq.size(), 0);
  endtask
  // monitor: pops the scoreboard on every DELAY_UPDATE rise and every DONE
  int rise_t = 0;
  logic prev_upd = 1'b0;
  always @(negedge CLK) begin
    if (!RESET_N) prev_upd = 1'b0;
    else begin
      if (DELAY_UPDATE && !prev_upd) begin
        if (pq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_pulse: got ch %0d, expected none (cycle %0d)", DELAY_CHANNEL, cyc);
        end else begin
          pulse_t p;
          p = pq.pop_front();
          chk("pulse_channel", int'(DELAY_CHANNEL), p.ch);
          chk("pulse_value", int'(DELAY_VALUE), p.val);
          chk("pulse_cycle", cyc, p.t);
          chk("busy_in_pulse", int'(BUSY), 1);
        end
        rise_t = cyc;
      end
      if (!DELAY_UPDATE && prev_upd) chk("pulse_width", cyc - rise_t, 2);
      if (DONE) begin
        if (dq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done: got DONE, expected none (cycle %0d)", cyc);
        end else chk("done_cycle", cyc, dq.pop_front());
        chk("busy_at_done", int'(BUSY), 0);
      end
      prev_upd = DELAY_UPDATE;
    end
  end
  initial begin
    int k;
    for (int i = 0; i < N; i++) mdl[i] = 0;
    repeat (3) tick();
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_done", int'(DONE), 0);
    chk("rst_update", int'(DELAY_UPDATE), 0);
    chk("rst_channel", int'(DELAY_CHANNEL), 0);
    chk("rst_value", int'(DELAY_VALUE), 0);
    chk("rst_rdata", int'(CFG_RDATA), 0);
    RESET_N = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < N; i++) rd(i, 0, "rst_table");
    for (int i = 0; i < N; i++) wr(i, i + 3);
    rd(0, 3, "rd_entry0");
    rd(20, 23, "rd_entry20");
    start_seq(k);
    push_seq(k, N, N, 0);
    drain(400);
    chk("idle_channel_kept", int'(DELAY_CHANNEL), 20);
    chk("idle_busy", int'(BUSY), 0);
    start_seq(k);
    push_seq(k, N, 6, 16);
    go_to(k + 43);
    RDY = 1'b0;
    go_to(k + 53);
    chk("busy_rdy_stall", int'(BUSY), 1);
    go_to(k + 63);
    chk("busy_rdy_stall_end", int'(BUSY), 1);
    RDY = 1'b1;
    drain(400);
    START = 1'b1;
    k = cyc;
    tick();
    START = 1'b0;
    push_seq(k, N, N, 0);
    push_seq(k + 169, N, N, 0);
    go_to(k + 20);
    pulse_start();
    go_to(k + 40);
    pulse_start();
    drain(700);
    repeat (20) tick();
    chk("idle_after_pending", int'(BUSY), 0);
    mdl[15] = 31;
    start_seq(k);
    push_seq(k, N, N, 0);
    go_to(k + 84);
    wr(15, 31);
    wr(3, 31);
    wr(200, 7);
    rd(200, 0, "rd_out_of_range");
    drain(400);
    rd(3, 31, "rd_late_write3");
    rd(15, 31, "rd_early_write15");
    start_seq(k);
    push_seq(k, 7, N, 0);
    go_to(k + 59);
    chk("pre_rst_update", int'(DELAY_UPDATE), 1);
    chk("pre_rst_channel", int'(DELAY_CHANNEL), 7);
    chk("pre_rst_value", int'(DELAY_VALUE), 10);
    RESET_N = 1'b0;
    #1;
    chk("async_rst_update", int'(DELAY_UPDATE), 0);
    chk("async_rst_busy", int'(BUSY), 0);
    chk("async_rst_channel", int'(DELAY_CHANNEL), 0);
    for (int i = 0; i < N; i++) mdl[i] = 0;
    repeat (3) tick();
    RESET_N = 1'b1;
    repeat (4) tick();
    chk("post_rst_left", pq.size() + dq.size(), 0);
    rd(15, 0, "rd_cleared15");
    rd(3, 0, "rd_cleared3");
    start_seq(k);
    push_seq(k, N, N, 0);
    drain(400);
    repeat (10) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
